// File: rtl/alien_hit_manager.sv
// alien_hit_manager: alive/dead state of the alien formation, bullet hit test
// and erase-pixel stream for a killed alien's sprite rectangle.
// Ports:
//   clk, reset (sync, active-high)
//   bulletValid/bulletX/bulletY   : bullet position strobe from the shot block
//   gridX/gridY                   : formation origin from the grid-movement block
//   collidedWithAlien             : one-cycle hit pulse back to the shot block
//   busy                          : checking or erasing; strobes dropped while high
//   aliveMask/aliensLeft/allDead  : formation status
//   eraseX/eraseY/eraseColour/eraseDrawEn : pixel plotter stream
// Latency: 1 cycle to decide hit or miss, then ALIEN_W*ALIEN_H erase cycles.
module alien_hit_manager #(
  parameter int ROWS         = 4,
  parameter int COLS         = 8,
  parameter int PITCH_X_LOG2 = 4,
  parameter int PITCH_Y_LOG2 = 3,
  parameter int ALIEN_W      = 12,
  parameter int ALIEN_H      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bulletValid,
  input  logic [7:0]           bulletX,
  input  logic [6:0]           bulletY,
  input  logic [7:0]           gridX,
  input  logic [6:0]           gridY,
  output logic                 collidedWithAlien,
  output logic                 busy,
  output logic [ROWS*COLS-1:0] aliveMask,
  output logic [5:0]           aliensLeft,
  output logic                 allDead,
  output logic [7:0]           eraseX,
  output logic [6:0]           eraseY,
  output logic [2:0]           eraseColour,
  output logic                 eraseDrawEn
);

  localparam int N   = ROWS * COLS;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int PXW = (ALIEN_W > 1) ? $clog2(ALIEN_W) : 1;
  localparam int PYW = (ALIEN_H > 1) ? $clog2(ALIEN_H) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, ERASE} state_t;

  state_t           r_state;
  logic [7:0]       r_bx;
  logic [6:0]       r_by;
  logic [7:0]       r_gx;
  logic [6:0]       r_gy;
  logic [7:0]       r_cx;
  logic [6:0]       r_cy;
  logic [PXW-1:0]   r_px;
  logic [PYW-1:0]   r_py;
  logic [N-1:0]     r_alive;
  logic [5:0]       r_left;
  logic             r_coll;
  logic             r_erase_en;
  logic [7:0]       r_erase_x;
  logic [6:0]       r_erase_y;

  // Offsets from the grid origin, one bit wider than the coordinates so the
  // MSB is the sign (bullet left of / above the formation).
  logic [8:0]       w_dx;
  logic [7:0]       w_dy;
  logic [8:0]       w_col;
  logic [7:0]       w_row;
  logic [8:0]       w_offx;
  logic [7:0]       w_offy;
  logic             w_in_sprite;
  logic [IW-1:0]    w_idx;
  logic             w_hit;
  logic [7:0]       w_cx;
  logic [6:0]       w_cy;
  logic             w_px_last;
  logic             w_py_last;
  logic [PXW-1:0]   w_px_next;

  assign w_dx   = {1'b0, r_bx} - {1'b0, r_gx};
  assign w_dy   = {1'b0, r_by} - {1'b0, r_gy};
  assign w_col  = w_dx >> PITCH_X_LOG2;
  assign w_row  = w_dy >> PITCH_Y_LOG2;
  assign w_offx = w_dx & 9'((1 << PITCH_X_LOG2) - 1);
  assign w_offy = w_dy & 8'((1 << PITCH_Y_LOG2) - 1);

  // Inside the formation and on the sprite, not in the gap between cells.
  assign w_in_sprite = !w_dx[8] && !w_dy[7] &&
                       (w_col < 9'(COLS)) && (w_row < 8'(ROWS)) &&
                       (w_offx < 9'(ALIEN_W)) && (w_offy < 8'(ALIEN_H));

  // Only meaningful when w_in_sprite; the && below guards the lookup.
  assign w_idx = IW'(w_row) * IW'(COLS) + IW'(w_col);
  assign w_hit = w_in_sprite && r_alive[w_idx];

  // Cell origin of the struck alien; wraps like the rest of the pixel maths.
  assign w_cx = r_gx + 8'(w_col << PITCH_X_LOG2);
  assign w_cy = r_gy + 7'(w_row << PITCH_Y_LOG2);

  assign w_px_last = (r_px == PXW'(ALIEN_W - 1));
  assign w_py_last = (r_py == PYW'(ALIEN_H - 1));
  assign w_px_next = r_px + PXW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bx       <= '0;
      r_by       <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_alive    <= '1;
      r_left     <= 6'(N);
      r_coll     <= 1'b0;
      r_erase_en <= 1'b0;
      r_erase_x  <= '0;
      r_erase_y  <= '0;
    end else begin
      r_coll <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bulletValid) begin
            r_bx    <= bulletX;
            r_by    <= bulletY;
            r_gx    <= gridX;
            r_gy    <= gridY;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_hit) begin
            r_alive[w_idx] <= 1'b0;
            r_left         <= r_left - 6'd1;
            r_coll         <= 1'b1;
            r_cx           <= w_cx;
            r_cy           <= w_cy;
            r_px           <= '0;
            r_py           <= '0;
            // First pixel (0,0) is presented in the cycle right after the hit.
            r_erase_en     <= 1'b1;
            r_erase_x      <= w_cx;
            r_erase_y      <= w_cy;
            r_state        <= ERASE;
          end else begin
            r_state <= IDLE;
          end
        end
        ERASE: begin
          // Outputs hold the current pixel; load the next one (row-major).
          if (w_px_last) begin
            if (w_py_last) begin
              r_erase_en <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_px      <= '0;
              r_py      <= r_py + PYW'(1);
              r_erase_x <= r_cx;
              r_erase_y <= r_cy + 7'(r_py) + 7'd1;
            end
          end else begin
            r_px      <= w_px_next;
            r_erase_x <= r_cx + 8'(w_px_next);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy              = (r_state != IDLE);
  assign collidedWithAlien = r_coll;
  assign aliveMask         = r_alive;
  assign aliensLeft        = r_left;
  assign allDead           = (r_left == 6'd0);
  assign eraseX            = r_erase_x;
  assign eraseY            = r_erase_y;
  assign eraseColour       = 3'b000;
  assign eraseDrawEn       = r_erase_en;

endmodule

// File: tb/tb_alien_hit_manager.sv
// Directed bench for alien_hit_manager: table of bullet strobes with
// hand-computed hit/miss, erased cell origin and busy-time corner cases.
module tb_alien_hit_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        bulletValid;
  logic [7:0]  bulletX;
  logic [6:0]  bulletY;
  logic [7:0]  gridX;
  logic [6:0]  gridY;
  logic        collidedWithAlien;
  logic        busy;
  logic [31:0] aliveMask;
  logic [5:0]  aliensLeft;
  logic        allDead;
  logic [7:0]  eraseX;
  logic [6:0]  eraseY;
  logic [2:0]  eraseColour;
  logic        eraseDrawEn;

  alien_hit_manager dut (
    .clk               (clk),
    .reset             (reset),
    .bulletValid       (bulletValid),
    .bulletX           (bulletX),
    .bulletY           (bulletY),
    .gridX             (gridX),
    .gridY             (gridY),
    .collidedWithAlien (collidedWithAlien),
    .busy              (busy),
    .aliveMask         (aliveMask),
    .aliensLeft        (aliensLeft),
    .allDead           (allDead),
    .eraseX            (eraseX),
    .eraseY            (eraseY),
    .eraseColour       (eraseColour),
    .eraseDrawEn       (eraseDrawEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bx;
    logic [6:0] by;
    logic [7:0] gx;
    logic [6:0] gy;
    bit         hit;
    int         idx;
    logic [7:0] cx;
    logic [6:0] cy;
    int         strobe_at;  // erase pixel at which a second strobe is raised
    int         reset_at;   // erase pixel at which reset is raised
    logic [7:0] sx;
    logic [6:0] sy;
  } vec_t;

  vec_t        vecs[11];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_mask;
  int          exp_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_mask"}, aliveMask, exp_mask);
    chk({tag, "_left"}, 32'(aliensLeft), 32'(exp_left));
    chk({tag, "_dead"}, 32'(allDead), 32'(exp_left == 0));
  endtask

  task automatic shot(input vec_t v);
    bit aborted = 0;
    @(negedge clk);
    bulletValid = 1'b1;
    bulletX     = v.bx;
    bulletY     = v.by;
    gridX       = v.gx;
    gridY       = v.gy;
    @(negedge clk);
    bulletValid = 1'b0;
    chk("busy_check", 32'(busy), 1);
    chk("coll_early", 32'(collidedWithAlien), 0);
    if (v.hit) begin
      exp_mask[v.idx] = 1'b0;
      exp_left--;
      for (int p = 0; p < 72 && !aborted; p++) begin
        @(negedge clk);
        if (p == v.strobe_at + 1) bulletValid = 1'b0;
        chk("erase_en", 32'(eraseDrawEn), 1);
        chk("erase_x", 32'(eraseX), 32'(8'(v.cx + p % 12)));
        chk("erase_y", 32'(eraseY), 32'(7'(v.cy + p / 12)));
        chk("erase_col", 32'(eraseColour), 0);
        chk("coll_pulse", 32'(collidedWithAlien), 32'(p == 0));
        chk("busy_erase", 32'(busy), 1);
        if (p == 0) chk_status("hit");
        if (p == v.strobe_at) begin
          bulletValid = 1'b1;
          bulletX     = v.sx;
          bulletY     = v.sy;
        end
        if (p == v.reset_at) begin
          reset   = 1'b1;
          aborted = 1;
        end
      end
      @(negedge clk);
      bulletValid = 1'b0;
      if (aborted) begin
        reset    = 1'b0;
        exp_mask = '1;
        exp_left = 32;
        chk("rst_ex", 32'(eraseX), 0);
        chk("rst_ey", 32'(eraseY), 0);
      end
      chk("busy_after", 32'(busy), 0);
      chk("en_after", 32'(eraseDrawEn), 0);
      chk("coll_after", 32'(collidedWithAlien), 0);
      chk_status("after");
    end else begin
      @(negedge clk);
      chk("miss_busy", 32'(busy), 0);
      chk("miss_en", 32'(eraseDrawEn), 0);
      chk("miss_coll", 32'(collidedWithAlien), 0);
      chk_status("miss");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          bx      by     gx      gy     hit idx cx      cy     stb rst  sx      sy
    vecs[0]  = '{8'd73,  7'd28, 8'd20,  7'd10, 1, 19, 8'd68,  7'd26, 20, -1, 8'd25, 7'd12};
    vecs[1]  = '{8'd73,  7'd28, 8'd20,  7'd10, 0, 0,  8'd0,   7'd0,  -1, -1, 8'd0,  7'd0};
    vecs[2]  = '{8'd81,  7'd28, 8'd20,  7'd10, 0, 0,  8'd0,   7'd0,  -1, -1, 8'd0,  7'd0};
    vecs[3]  = '{8'd10,  7'd28, 8'd20,  7'd10, 0, 0,  8'd0,   7'd0,  -1, -1, 8'd0,  7'd0};
    vecs[4]  = '{8'd30,  7'd50, 8'd20,  7'd10, 0, 0,  8'd0,   7'd0,  -1, -1, 8'd0,  7'd0};
    vecs[5]  = '{8'd25,  7'd12, 8'd20,  7'd10, 1, 0,  8'd20,  7'd10, 71, -1, 8'd41, 7'd12};
    vecs[6]  = '{8'd41,  7'd12, 8'd20,  7'd10, 1, 1,  8'd36,  7'd10, -1, 40, 8'd0,  7'd0};
    vecs[7]  = '{8'd31,  7'd15, 8'd20,  7'd10, 1, 0,  8'd20,  7'd10, -1, -1, 8'd0,  7'd0};
    vecs[8]  = '{8'd48,  7'd15, 8'd20,  7'd10, 0, 0,  8'd0,   7'd0,  -1, -1, 8'd0,  7'd0};
    vecs[9]  = '{8'd47,  7'd16, 8'd20,  7'd10, 0, 0,  8'd0,   7'd0,  -1, -1, 8'd0,  7'd0};
    vecs[10] = '{8'd223, 7'd49, 8'd100, 7'd20, 1, 31, 8'd212, 7'd44, -1, -1, 8'd0,  7'd0};

    reset       = 1'b1;
    bulletValid = 1'b0;
    bulletX     = '0;
    bulletY     = '0;
    gridX       = '0;
    gridY       = '0;
    exp_mask    = '1;
    exp_left    = 32;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_status("reset");
    chk("reset_busy", 32'(busy), 0);
    chk("reset_en", 32'(eraseDrawEn), 0);
    chk("reset_coll", 32'(collidedWithAlien), 0);
    chk("reset_ex", 32'(eraseX), 0);
    chk("reset_ey", 32'(eraseY), 0);

    for (int i = 0; i < 11; i++) shot(vecs[i]);

    // Column 8 is just past the right edge of the formation.
    v = '{8'd229, 7'd21, 8'd100, 7'd20, 0, 0, 8'd0, 7'd0, -1, -1, 8'd0, 7'd0};
    shot(v);

    // Fresh formation, then shoot every alien once.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    exp_mask = '1;
    exp_left = 32;
    chk_status("reset2");
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        v = '{8'(20 + c * 16 + 2), 7'(10 + r * 8 + 1), 8'd20, 7'd10, 1, r * 8 + c,
              8'(20 + c * 16), 7'(10 + r * 8), -1, -1, 8'd0, 7'd0};
        shot(v);
      end
    end
    chk("all_dead_left", 32'(aliensLeft), 0);
    chk("all_dead_flag", 32'(allDead), 1);
    v = '{8'd73, 7'd28, 8'd20, 7'd10, 0, 0, 8'd0, 7'd0, -1, -1, 8'd0, 7'd0};
    shot(v);
    chk("dead_sticky", 32'(allDead), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
